// File: rtl/fetch_rom_arbiter.sv
// fetch_rom_arbiter
//   Lets core 0 and core 1 share one combinational, single-ported
//   instruction ROM. Each cycle at most one eligible fetch stage is granted.
//   When both cores are eligible, the grant goes to the core that did not
//   win the last grant. The ROM address follows the winner's PC in the same
//   cycle. The fetched word is registered back to that core, so it arrives
//   with one cycle of latency. The losing core sees a stall. Halts are sticky
//   per core, and cycles with contention are counted in a saturating counter.
//
// Ports
//   clk, reset                     clock; synchronous active-high reset
//   req_k, pc_k                    fetch request and fetch address of core k
//   hlt_k                          core k reached halt (sticky until reset)
//   flush_k                        cancels core k's fetch and its returning word
//   rom_addr / rom_rd_data         shared ROM address out / read data in
//   instr_k, instr_valid_k         registered word and its one-cycle valid
//   stall_fetch_k                  core k eligible but not granted
//   last_grant                     core that won the most recent grant
//   conflict_cnt                   saturating count of cycles with both cores eligible
module fetch_rom_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_0,
  input  logic [ADDR_W-1:0] pc_0,
  input  logic              hlt_0,
  input  logic              flush_0,
  input  logic              req_1,
  input  logic [ADDR_W-1:0] pc_1,
  input  logic              hlt_1,
  input  logic              flush_1,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_rd_data,
  output logic [DATA_W-1:0] instr_0,
  output logic              instr_valid_0,
  output logic              stall_fetch_0,
  output logic [DATA_W-1:0] instr_1,
  output logic              instr_valid_1,
  output logic              stall_fetch_1,
  output logic              last_grant,
  output logic [CNT_W-1:0]  conflict_cnt
);

  // The halt state is simply a view of the two sticky per-core flags.
  typedef enum logic [1:0] {
    RUN       = 2'b00,
    HALT0     = 2'b01,
    HALT1     = 2'b10,
    HALT_BOTH = 2'b11
  } halt_state_t;

  logic        halted_0, halted_1;
  halt_state_t halt_state;
  logic        eligible_0, eligible_1;
  logic        grant_0, grant_1;
  logic        valid_q_0, valid_q_1;

  assign halt_state = halt_state_t'({halted_1, halted_0});

  // hlt_k and flush_k block a grant in the same cycle they are raised.
  assign eligible_0 = req_0 & ~halted_0 & ~hlt_0 & ~flush_0;
  assign eligible_1 = req_1 & ~halted_1 & ~hlt_1 & ~flush_1;

  // Round-robin: if both cores are eligible, the core that did not win
  // last time takes the grant.
  assign grant_0 = eligible_0 & (~eligible_1 | last_grant);
  assign grant_1 = eligible_1 & (~eligible_0 | ~last_grant);

  // A core never stalls during reset.
  assign stall_fetch_0 = ~reset & eligible_0 & ~grant_0;
  assign stall_fetch_1 = ~reset & eligible_1 & ~grant_1;

  // A flush that arrives in the return cycle hides the word from decode
  // right away. The register itself is cleared at the next edge.
  assign instr_valid_0 = valid_q_0 & ~flush_0;
  assign instr_valid_1 = valid_q_1 & ~flush_1;

  always_comb begin
    // NOTE: assign the default first so that no path leaves rom_addr
    // unassigned, which would otherwise infer a latch.
    rom_addr = '0;
    if (halt_state != HALT_BOTH) begin
      if (grant_0)      rom_addr = pc_0;
      else if (grant_1) rom_addr = pc_1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      halted_0     <= 1'b0;
      halted_1     <= 1'b0;
      instr_0      <= '0;
      instr_1      <= '0;
      valid_q_0    <= 1'b0;
      valid_q_1    <= 1'b0;
      last_grant   <= 1'b1;  // core 0 wins the first conflict after reset
      conflict_cnt <= '0;
    end else begin
      // NOTE: use non-blocking assignments so that every register here
      // samples the values from before the edge, whatever the statement order.
      halted_0 <= halted_0 | hlt_0;
      halted_1 <= halted_1 | hlt_1;

      if (grant_0) begin
        instr_0   <= rom_rd_data;
        valid_q_0 <= 1'b1;
      end else begin
        valid_q_0 <= 1'b0;
        if (valid_q_0 && flush_0) instr_0 <= '0;
      end

      if (grant_1) begin
        instr_1   <= rom_rd_data;
        valid_q_1 <= 1'b1;
      end else begin
        valid_q_1 <= 1'b0;
        if (valid_q_1 && flush_1) instr_1 <= '0;
      end

      if (grant_0 || grant_1) last_grant <= grant_1;

      if (eligible_0 && eligible_1 && (conflict_cnt != {CNT_W{1'b1}}))
        conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_rom_arbiter.sv
// Testbench for fetch_rom_arbiter.
//   Each stimulus cycle is a vector record: the inputs, the core expected to
//   win (0 = none, 1 = core 0, 2 = core 1), the expected stalls, and whether
//   the cycle is a contention cycle. A grant pushes the expected word onto a
//   scoreboard queue. The entry is popped and compared on the return cycle.
module tb_fetch_rom_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_0, req_1, hlt_0, hlt_1, flush_0, flush_1;
  logic [ADDR_W-1:0] pc_0, pc_1, rom_addr;
  logic [DATA_W-1:0] rom_rd_data, instr_0, instr_1;
  logic              instr_valid_0, instr_valid_1, stall_fetch_0, stall_fetch_1;
  logic              last_grant;
  logic [CNT_W-1:0]  conflict_cnt;

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign rom_rd_data = rom_word(rom_addr);

  fetch_rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req_0(req_0), .pc_0(pc_0), .hlt_0(hlt_0), .flush_0(flush_0),
    .req_1(req_1), .pc_1(pc_1), .hlt_1(hlt_1), .flush_1(flush_1),
    .rom_addr(rom_addr), .rom_rd_data(rom_rd_data),
    .instr_0(instr_0), .instr_valid_0(instr_valid_0), .stall_fetch_0(stall_fetch_0),
    .instr_1(instr_1), .instr_valid_1(instr_valid_1), .stall_fetch_1(stall_fetch_1),
    .last_grant(last_grant), .conflict_cnt(conflict_cnt)
  );

  typedef struct {
    bit              rst;
    bit              r0, r1;
    logic [ADDR_W-1:0] p0, p1;
    bit              h0, h1, f0, f1;
    int              gnt;    // 0 none, 1 core 0, 2 core 1
    bit              s0, s1; // expected stalls
    bit              conf;   // both cores eligible this cycle
  } vec_t;

  typedef struct {
    bit              core;
    logic [DATA_W-1:0] word;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  logic [DATA_W-1:0] exp_instr0, exp_instr1;
  logic              exp_last;
  int                exp_cnt;

  function automatic vec_t mk(bit rst, bit r0, logic [ADDR_W-1:0] p0, bit r1,
                              logic [ADDR_W-1:0] p1, bit h0, bit h1, bit f0,
                              bit f1, int gnt, bit s0, bit s1, bit conf);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.p0 = p0; v.r1 = r1; v.p1 = p1;
    v.h0 = h0; v.h1 = h1; v.f0 = f0; v.f1 = f1;
    v.gnt = gnt; v.s0 = s0; v.s1 = s1; v.conf = conf;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle: drive after the edge, check mid-cycle, then advance.
  task automatic step(input vec_t v, input int idx);
    sb_t e;
    bit  have_e;
    bit  ev0, ev1;
    logic [ADDR_W-1:0] ea;
    reset = v.rst;
    req_0 = v.r0; pc_0 = v.p0; hlt_0 = v.h0; flush_0 = v.f0;
    req_1 = v.r1; pc_1 = v.p1; hlt_1 = v.h1; flush_1 = v.f1;
    #4;
    have_e = (sb.size() > 0);
    if (have_e) e = sb.pop_front();
    if (v.rst) begin
      check($sformatf("v%0d stall_0 in reset", idx), 64'(stall_fetch_0), 64'd0);
      check($sformatf("v%0d stall_1 in reset", idx), 64'(stall_fetch_1), 64'd0);
      sb.delete();
      exp_instr0 = '0; exp_instr1 = '0; exp_last = 1'b1; exp_cnt = 0;
    end else begin
      ev0 = have_e && (e.core == 1'b0) && !v.f0;
      ev1 = have_e && (e.core == 1'b1) && !v.f1;
      if (have_e && e.core == 1'b0) exp_instr0 = e.word;
      if (have_e && e.core == 1'b1) exp_instr1 = e.word;
      ea = (v.gnt == 1) ? v.p0 : (v.gnt == 2) ? v.p1 : '0;
      check($sformatf("v%0d rom_addr", idx), 64'(rom_addr), 64'(ea));
      check($sformatf("v%0d stall_0", idx), 64'(stall_fetch_0), 64'(v.s0));
      check($sformatf("v%0d stall_1", idx), 64'(stall_fetch_1), 64'(v.s1));
      check($sformatf("v%0d valid_0", idx), 64'(instr_valid_0), 64'(ev0));
      check($sformatf("v%0d valid_1", idx), 64'(instr_valid_1), 64'(ev1));
      check($sformatf("v%0d instr_0", idx), 64'(instr_0), 64'(exp_instr0));
      check($sformatf("v%0d instr_1", idx), 64'(instr_1), 64'(exp_instr1));
      check($sformatf("v%0d last_grant", idx), 64'(last_grant), 64'(exp_last));
      check($sformatf("v%0d conflict_cnt", idx), 64'(conflict_cnt), 64'(exp_cnt));
      // A word that is flushed on its return cycle is cleared at the next edge.
      if (have_e && e.core == 1'b0 && v.f0) exp_instr0 = '0;
      if (have_e && e.core == 1'b1 && v.f1) exp_instr1 = '0;
      if (v.gnt != 0) begin
        e.core = (v.gnt == 2);
        e.word = rom_word(ea);
        sb.push_back(e);
        exp_last = (v.gnt == 2);
      end
      if (v.conf && exp_cnt < 15) exp_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    //          rst r0 p0     r1 p1     h0 h1 f0 f1 gnt s0 s1 conf
    vecs.push_back(mk(1, 0, 0,     0, 0,     0, 0, 0, 0, 0, 0, 0, 0));
    // Single requester; the word returns one cycle later.
    vecs.push_back(mk(0, 1, 'h10,  0, 0,     0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,     0, 0,     0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,     0, 0,     0, 0, 0, 0, 0, 0, 0, 0));
    // Continuous contention after reset: grants go 0,1,0,1.
    vecs.push_back(mk(1, 0, 0,     0, 0,     0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 'h20,  1, 'h40,  0, 0, 0, 0, 1, 0, 1, 1));
    vecs.push_back(mk(0, 1, 'h20,  1, 'h40,  0, 0, 0, 0, 2, 1, 0, 1));
    vecs.push_back(mk(0, 1, 'h20,  1, 'h40,  0, 0, 0, 0, 1, 0, 1, 1));
    vecs.push_back(mk(0, 1, 'h20,  1, 'h40,  0, 0, 0, 0, 2, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0,     0, 0,     0, 0, 0, 0, 0, 0, 0, 0));
    // Core 1 word flushed on its return cycle; core 0 fetches alongside.
    vecs.push_back(mk(0, 0, 0,     1, 'h8,   0, 0, 0, 0, 2, 0, 0, 0));
    vecs.push_back(mk(0, 1, 'h30,  1, 'hC,   0, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,     0, 0,     0, 0, 0, 0, 0, 0, 0, 0));
    // Core 0 halts while both request; core 1 then owns the ROM.
    vecs.push_back(mk(0, 1, 'h50,  1, 'h60,  1, 0, 0, 0, 2, 0, 0, 0));
    vecs.push_back(mk(0, 1, 'h50,  1, 'h64,  0, 0, 0, 0, 2, 0, 0, 0));
    vecs.push_back(mk(0, 1, 'h54,  1, 'h68,  0, 0, 0, 0, 2, 0, 0, 0));
    vecs.push_back(mk(0, 1, 'h58,  0, 0,     0, 0, 0, 0, 0, 0, 0, 0));
    // Reset during a core 0 return; core 0 wins the next conflict.
    vecs.push_back(mk(1, 0, 0,     0, 0,     0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 'h70,  0, 0,     0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 'h74,  1, 'h84,  0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 'h74,  1, 'h84,  0, 0, 0, 0, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0,     0, 0,     0, 0, 0, 0, 0, 0, 0, 0));
    // Core 1 halt blocks its grant in the same cycle; then both halt.
    vecs.push_back(mk(0, 0, 0,     1, 'h90,  0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 'hA0,  1, 'h94,  0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 'hA4,  0, 0,     1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 'hA8,  1, 'h98,  0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,     0, 0,     0, 0, 0, 0, 0, 0, 0, 0));
    // Saturation of the 4-bit contention counter: 20 conflict cycles.
    vecs.push_back(mk(1, 0, 0,     0, 0,     0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0)
        vecs.push_back(mk(0, 1, 32'h100 + i, 1, 32'h200 + i, 0, 0, 0, 0, 1, 0, 1, 1));
      else
        vecs.push_back(mk(0, 1, 32'h100 + i, 1, 32'h200 + i, 0, 0, 0, 0, 2, 1, 0, 1));
    end
    vecs.push_back(mk(0, 0, 0,     0, 0,     0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,     0, 0,     0, 0, 0, 0, 0, 0, 0, 0));

    exp_instr0 = '0; exp_instr1 = '0; exp_last = 1'b1; exp_cnt = 0;
    reset = 1'b1;
    req_0 = 0; req_1 = 0; hlt_0 = 0; hlt_1 = 0; flush_0 = 0; flush_1 = 0;
    pc_0 = '0; pc_1 = '0;
    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
